mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4:1 mux (select lines s1,s0; data inputs a,b,c,d)

---
 rtl/mux4_rr_arbiter_if.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the four requesters and the shared 4:1 mux arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       s0;
    logic       s1;
    logic       valid;

    modport master (
        output req,
        input  grant,
        input  s0,
        input  s1,
        input  valid
    );

    modport slave (
        input  req,
        output grant,
        output s0,
        output s1,
        output valid
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// Requester i owns mux input i; {s1,s0} selects it while its grant is active.
// Each tenure is capped at HOLD_CYCLES and followed by at least one idle cycle
// so the mux has a quiet cycle to settle between owners.
module mux4_rr_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             release_now;

    // Find the first requesting index, searching upward from ptr with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The owner gives up the mux when it stops asking or its tenure is used up;
    // both causes together still form a single release.
    always_comb begin
        release_now = ~bus.req[sel_q] | (cnt_q == HOLD_LAST);
    end

    // Next-state logic: IDLE grants on the same edge a request is seen,
    // GRANT either extends the tenure or drops back to IDLE for one dead cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Select lines keep their last value; only grant/valid drop.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset also clears the fairness pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: three instances (HOLD_CYCLES 4, 3, 1)
// share clock and reset. Stimulus pushes hand-computed expected outputs; a
// monitor pops one entry per clock and compares the addressed instance.
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst;

    mux4_rr_arbiter_if if0();
    mux4_rr_arbiter_if if1();
    mux4_rr_arbiter_if if2();

    mux4_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux4_rr_arbiter #(.HOLD_CYCLES(3), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mux4_rr_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        int         dut;
        logic [6:0] exp;   // {grant[3:0], s1, s0, valid}
        string      name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dut_out(input int d);
        case (d)
            0:       return {if0.grant, if0.s1, if0.s0, if0.valid};
            1:       return {if1.grant, if1.s1, if1.s0, if1.valid};
            default: return {if2.grant, if2.s1, if2.s0, if2.valid};
        endcase
    endfunction

    task automatic compare(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got grant=%b s1s0=%b valid=%b, want grant=%b s1s0=%b valid=%b",
                     nm, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    // Monitor: one pop per clock, shortly after the active edge.
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e.name, dut_out(e.dut), e.exp);
        end
    end

    // Drive req of one instance before the next edge and queue what must follow it.
    task automatic step(input int d, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] sl, input logic v, input string nm);
        sb_entry_t e;
        @(negedge clk);
        if0.req = (d == 0) ? r : 4'b0000;
        if1.req = (d == 1) ? r : 4'b0000;
        if2.req = (d == 2) ? r : 4'b0000;
        e.dut  = d;
        e.exp  = {g, sl, v};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if0.req = 4'b0000;
        if1.req = 4'b0000;
        if2.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        sb_entry_t  e;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        if0.req  = 4'b0000;
        if1.req  = 4'b0000;
        if2.req  = 4'b0000;
        #2;
        compare("reset_dut0", dut_out(0), 7'b0000_00_0);
        compare("reset_dut1", dut_out(1), 7'b0000_00_0);
        compare("reset_dut2", dut_out(2), 7'b0000_00_0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: single requester for two cycles, then select lines hold.
        step(0, 4'b0100, 4'b0100, 2'b10, 1'b1, "t1_grant_c0");
        step(0, 4'b0100, 4'b0100, 2'b10, 1'b1, "t1_grant_c1");
        step(0, 4'b0000, 4'b0000, 2'b10, 1'b0, "t1_release");
        step(0, 4'b0000, 4'b0000, 2'b10, 1'b0, "t1_idle_hold_sel");

        // Test 2: all requesting, 4 on / 1 off rotation.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            g = 4'b0001 << t;
            for (int c = 0; c < 4; c++)
                step(0, 4'b1111, g, 2'(t), 1'b1, $sformatf("t2_req%0d_c%0d", t, c));
            step(0, 4'b1111, 4'b0000, 2'(t), 1'b0, $sformatf("t2_dead%0d", t));
        end
        step(0, 4'b1111, 4'b0001, 2'b00, 1'b1, "t2_wrap");

        // Test 3: req=1010 alternates between indices 1 and 3.
        do_reset();
        for (int c = 0; c < 4; c++) step(0, 4'b1010, 4'b0010, 2'b01, 1'b1, $sformatf("t3_a_c%0d", c));
        step(0, 4'b1010, 4'b0000, 2'b01, 1'b0, "t3_dead_a");
        for (int c = 0; c < 4; c++) step(0, 4'b1010, 4'b1000, 2'b11, 1'b1, $sformatf("t3_b_c%0d", c));
        step(0, 4'b1010, 4'b0000, 2'b11, 1'b0, "t3_dead_b");
        for (int c = 0; c < 4; c++) step(0, 4'b1010, 4'b0010, 2'b01, 1'b1, $sformatf("t3_c_c%0d", c));
        step(0, 4'b1010, 4'b0000, 2'b01, 1'b0, "t3_dead_c");
        step(0, 4'b1010, 4'b1000, 2'b11, 1'b1, "t3_d_c0");

        // Test 4: asynchronous reset in the middle of the 1000 tenure.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        compare("t4_async_reset", dut_out(0), 7'b0000_00_0);
        @(negedge clk);
        rst = 1'b0;
        if0.req = 4'b1001;
        e.dut  = 0;
        e.exp  = {4'b0001, 2'b00, 1'b1};
        e.name = "t4_ptr_cleared";
        sb.push_back(e);

        // Test 5 (HOLD_CYCLES=3): drop and hold limit coincide; ptr moves to 2 once.
        do_reset();
        step(1, 4'b0010, 4'b0010, 2'b01, 1'b1, "t5_c0");
        step(1, 4'b0010, 4'b0010, 2'b01, 1'b1, "t5_c1");
        step(1, 4'b0010, 4'b0010, 2'b01, 1'b1, "t5_c2");
        step(1, 4'b1100, 4'b0000, 2'b01, 1'b0, "t5_double_release");
        step(1, 4'b1100, 4'b0100, 2'b10, 1'b1, "t5_next_idx2");

        // Test 6 (HOLD_CYCLES=1): grant toggles every cycle.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(2, 4'b0001, 4'b0001, 2'b00, 1'b1, $sformatf("t6_on%0d", c));
            step(2, 4'b0001, 4'b0000, 2'b00, 1'b0, $sformatf("t6_off%0d", c));
        end

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
